// File: rtl/regfile_pkg.sv
// Shared constants for the 32x32 register file.
//   REGFILE_DATA_WIDTH : default bits per register
//   REGFILE_ADDR_WIDTH : default register address bits
//   ZERO_REG           : register number that is hardwired to zero
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_WIDTH = 32;
    localparam int unsigned REGFILE_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_REG           = 0;

endpackage : regfile_pkg

// File: rtl/decode5to32.sv
// Full binary-to-one-hot decoder used to build the register write strobes.
//   IN     : binary select (5 bits by default)
//   ENABLE : when low, every output is zero
//   OUT    : one-hot strobe vector (32 bits by default)
module decode5to32 #(
    parameter int unsigned IN_WIDTH = 5
) (
    input  logic [IN_WIDTH-1:0]      IN,
    input  logic                     ENABLE,
    output logic [(2**IN_WIDTH)-1:0] OUT
);

    always_comb begin
        OUT = '0;
        if (ENABLE) begin
            OUT[IN] = 1'b1;
        end
    end

endmodule : decode5to32

// File: rtl/register_file_32x32.sv
// Register file with one write port and two independent combinational read ports.
//   CLK          : clock, all writes on the rising edge
//   RESET        : asynchronous active-high clear of every register
//   WRITE_ENABLE : write request for this cycle
//   WRITE_ADDR   : destination register
//   WRITE_DATA   : value to store
//   READ_ADDR1/2 : read port register numbers
//   READ_DATA1/2 : addressed register contents (register 0 always reads 0)
module register_file_32x32
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE_ENABLE,
    input  logic [ADDR_WIDTH-1:0] WRITE_ADDR,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic [ADDR_WIDTH-1:0] READ_ADDR1,
    input  logic [ADDR_WIDTH-1:0] READ_ADDR2,
    output logic [DATA_WIDTH-1:0] READ_DATA1,
    output logic [DATA_WIDTH-1:0] READ_DATA2
);

    localparam int unsigned NumRegs = 2**ADDR_WIDTH;

    logic [NumRegs-1:0]    we_strobe;
    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    decode5to32 #(
        .IN_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .IN     (WRITE_ADDR),
        .ENABLE (WRITE_ENABLE),
        .OUT    (we_strobe)
    );

    // Strobe for register 0 is deliberately dropped so it never leaves zero.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (we_strobe[i] && (i != ZERO_REG)) begin
                regs_d[i] = WRITE_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Two separate selects so neither read port depends on the other.
    always_comb begin
        rd1 = regs_q[READ_ADDR1];
        if (RESET || (READ_ADDR1 == ADDR_WIDTH'(ZERO_REG))) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs_q[READ_ADDR2];
        if (RESET || (READ_ADDR2 == ADDR_WIDTH'(ZERO_REG))) begin
            rd2 = '0;
        end
    end

    assign READ_DATA1 = rd1;
    assign READ_DATA2 = rd2;

endmodule : register_file_32x32

// File: tb/tb_register_file_32x32.sv
// Self-checking bench for register_file_32x32: directed scenarios plus random traffic
// compared every cycle against an array model of the register file.
`timescale 1ns/1ps
module tb_register_file_32x32;

    logic        CLK;
    logic        RESET;
    logic        WRITE_ENABLE;
    logic [4:0]  WRITE_ADDR;
    logic [31:0] WRITE_DATA;
    logic [4:0]  READ_ADDR1;
    logic [4:0]  READ_ADDR2;
    logic [31:0] READ_DATA1;
    logic [31:0] READ_DATA2;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    logic [31:0] model [32];

    register_file_32x32 dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WRITE_ENABLE (WRITE_ENABLE),
        .WRITE_ADDR   (WRITE_ADDR),
        .WRITE_DATA   (WRITE_DATA),
        .READ_ADDR1   (READ_ADDR1),
        .READ_ADDR2   (READ_ADDR2),
        .READ_DATA1   (READ_DATA1),
        .READ_DATA2   (READ_DATA2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: array of 32 words, word 0 never written, cleared by reset.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (WRITE_ENABLE && WRITE_ADDR != 5'd0) begin
            model[WRITE_ADDR] = WRITE_DATA;
        end
    end

    always @(posedge RESET) begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("cycle_rd1", READ_DATA1, RESET ? 32'h0 : model[READ_ADDR1]);
            chk("cycle_rd2", READ_DATA2, RESET ? 32'h0 : model[READ_ADDR2]);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        RESET = 1'b0;
        WRITE_ENABLE = 1'b0;
        WRITE_ADDR = '0;
        WRITE_DATA = '0;
        READ_ADDR1 = '0;
        READ_ADDR2 = '0;
        #2 RESET = 1'b1;
        #1 chk("reset_rd1", READ_DATA1, 32'h0);
        step();
        step();
        RESET = 1'b0;
        started = 1;

        // Reset state on a few addresses.
        READ_ADDR1 = 5'd5;  READ_ADDR2 = 5'd31;
        #1 chk("init_r5", READ_DATA1, 32'h0);
        chk("init_r31", READ_DATA2, 32'h0);

        // Write r5, then asynchronous reset mid-cycle clears it immediately.
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd5; WRITE_DATA = 32'hDEADBEEF;
        step();
        WRITE_ENABLE = 1'b0;
        READ_ADDR1 = 5'd5;
        #1 chk("r5_written", READ_DATA1, 32'hDEADBEEF);
        RESET = 1'b1;
        #1 chk("async_reset_r5", READ_DATA1, 32'h0);
        RESET = 1'b0;
        #1 chk("after_reset_r5", READ_DATA1, 32'h0);

        // Basic write/read on port 2, all other registers still zero.
        step();
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd7; WRITE_DATA = 32'h12345678;
        step();
        WRITE_ENABLE = 1'b0;
        READ_ADDR2 = 5'd7;
        #1 chk("r7_port2", READ_DATA2, 32'h12345678);
        for (int i = 0; i < 32; i++) begin
            if (i != 7) begin
                READ_ADDR1 = 5'(i);
                step();
                chk("others_zero", READ_DATA1, 32'h0);
            end
        end

        // Writes to register 0 are discarded.
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd0; WRITE_DATA = 32'hFFFFFFFF;
        step();
        WRITE_ENABLE = 1'b0;
        READ_ADDR1 = 5'd0;
        #1 chk("zero_reg", READ_DATA1, 32'h0);

        // Read during write returns the old value until the edge.
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd3; WRITE_DATA = 32'h11;
        step();
        WRITE_DATA = 32'h22;
        READ_ADDR1 = 5'd3;
        #1 chk("rdw_old", READ_DATA1, 32'h11);
        step();
        WRITE_ENABLE = 1'b0;
        #1 chk("rdw_new", READ_DATA1, 32'h22);

        // Disabled write leaves r9 alone.
        WRITE_ENABLE = 1'b0; WRITE_ADDR = 5'd9; WRITE_DATA = 32'hAAAA;
        step();
        READ_ADDR1 = 5'd9;
        #1 chk("we0_r9", READ_DATA1, 32'h0);

        // Full sweep.
        for (int i = 1; i < 32; i++) begin
            WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'(i); WRITE_DATA = 32'(i) * 32'h01010101;
            step();
        end
        WRITE_ENABLE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            READ_ADDR1 = 5'(i); READ_ADDR2 = 5'(i);
            #1 chk("sweep_p1", READ_DATA1, 32'(i) * 32'h01010101);
            chk("sweep_p2", READ_DATA2, 32'(i) * 32'h01010101);
            step();
        end

        // Write edge coinciding with reset assertion is ignored.
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd4; WRITE_DATA = 32'h5555;
        READ_ADDR1 = 5'd4;
        @(posedge CLK);
        RESET = 1'b1;
        #1 chk("coincident_reset", READ_DATA1, 32'h0);
        WRITE_ENABLE = 1'b0;
        step();
        RESET = 1'b0;
        #1 chk("coincident_after", READ_DATA1, 32'h0);
        // First edge after deassertion accepts the write.
        WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd4; WRITE_DATA = 32'h77;
        step();
        WRITE_ENABLE = 1'b0;
        #1 chk("first_write_after_reset", READ_DATA1, 32'h77);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step();
            RESET        = ($urandom_range(0, 149) == 0);
            WRITE_ENABLE = $urandom_range(0, 1) == 1;
            WRITE_ADDR   = 5'($urandom_range(0, 31));
            WRITE_DATA   = $urandom;
            READ_ADDR1   = 5'($urandom_range(0, 31));
            READ_ADDR2   = ($urandom_range(0, 7) == 0) ? READ_ADDR1 : 5'($urandom_range(0, 31));
        end
        step();
        RESET = 1'b0;
        WRITE_ENABLE = 1'b0;
        step();
        step();
        started = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file_32x32

// File: doc/register_file_32x32.md
REGISTER_FILE_32X32 -- requirements
Module: register_file_32x32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address bits (2**ADDR_WIDTH registers).
REQ-003 SHALL have port CLK input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET input 1: asynchronous, active-high reset.
REQ-005 SHALL have port WRITE_ENABLE input 1: write request for the current cycle.
REQ-006 SHALL have port WRITE_ADDR input ADDR_WIDTH: destination register number.
REQ-007 SHALL have port WRITE_DATA input DATA_WIDTH: value to store.
REQ-008 SHALL have port READ_ADDR1 input ADDR_WIDTH: read port 1 register number.
REQ-009 SHALL have port READ_ADDR2 input ADDR_WIDTH: read port 2 register number.
REQ-010 SHALL have port READ_DATA1 output DATA_WIDTH: contents of register READ_ADDR1.
REQ-011 SHALL have port READ_DATA2 output DATA_WIDTH: contents of register READ_ADDR2.

Function
REQ-012 SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, numbered 0 to 2**ADDR_WIDTH-1.
REQ-013 SHALL write WRITE_DATA into register WRITE_ADDR on the rising CLK edge when WRITE_ENABLE=1 and RESET=0.
REQ-014 SHALL leave every register unchanged on any edge where WRITE_ENABLE=0.
REQ-015 SHALL derive per-register write strobes by fully decoding WRITE_ADDR, gated by WRITE_ENABLE; exactly one strobe or none SHALL be active per cycle.
REQ-016 SHALL treat register 0 as hardwired zero: writes to address 0 are discarded, and reads of address 0 return 0.
REQ-017 SHALL drive READ_DATA1 and READ_DATA2 combinationally from the addressed stored value, with zero-cycle read latency.
REQ-018 SHALL return the pre-edge (old) value when a read address equals WRITE_ADDR during a write cycle; the new value appears after the edge, with no write-to-read bypass.
REQ-019 SHALL return the same value on both ports when READ_ADDR1 = READ_ADDR2.
REQ-020 SHALL make a written value visible on the read ports in the cycle after the write edge.

Reset
REQ-021 SHALL clear all registers to 0 immediately on RESET assertion, independent of CLK.
REQ-022 SHALL drive READ_DATA1 and READ_DATA2 to 0 for every address while RESET=1.
REQ-023 SHALL ignore WRITE_ENABLE while RESET=1, including a write edge that coincides with reset assertion.
REQ-024 SHALL accept writes from the first rising CLK edge after RESET deasserts.

Structure
REQ-025 SHALL place DATA_WIDTH and ADDR_WIDTH defaults and the register-number constant ZERO_REG=0 in the shared package regfile_pkg.
REQ-026 SHALL contain one decoder sub-module, decode5to32 (inputs IN[4:0] and ENABLE, output OUT[31:0], one-hot when ENABLE=1, all-zero otherwise), producing the write strobes.
REQ-027 SHALL implement read selection as two independent 32:1 multiplexers with no shared logic that would couple the ports.

Verification
REQ-028 SHALL cover reset: write 0xDEADBEEF to r5, assert RESET mid-cycle -> READ_DATA1 (addr 5) = 0 immediately, before the next CLK edge.
REQ-029 SHALL cover basic write/read: WE=1, addr 7, data 0x12345678, one edge -> READ_DATA2 (addr 7) = 0x12345678 in the next cycle; all other registers remain 0.
REQ-030 SHALL cover zero register: WE=1, addr 0, data 0xFFFFFFFF -> READ_DATA1 (addr 0) = 0x00000000.
REQ-031 SHALL cover read-during-write: r3 = 0x11, then write 0x22 to r3 with READ_ADDR1=3 -> 0x11 before the edge, 0x22 after it.
REQ-032 SHALL cover disabled write: WE=0, addr 9, data 0xAAAA -> r9 stays at its prior value 0.
REQ-033 SHALL cover a full sweep: write i*0x01010101 to r1..r31, then read each on both ports -> exact match, with r0 = 0 throughout.
